pov_message_engine: RTL and testbench

//  Parametrised successor to the POV display path. It assembles a message from a UART byte

---
 rtl/pov_message_engine.sv | 190 +++++++++++++++++++
 tb/tb_pov_message_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pov_message_engine.sv
// pov_message_engine: assembles a UART message into a double-buffered character
// store and sweeps the committed (front) message onto an LED column, one glyph
// column per COL_TICKS clocks, starting on each rising edge of the rotation sync.
// A new message is swapped in only while the display is idle, so a sweep never tears.
module pov_message_engine #(
  parameter int         MAX_CHARS     = 11,
  parameter int         CHAR_BITS     = 7,
  parameter int         NUM_LEDS      = 16,
  parameter int         COLS_PER_CHAR = 5,
  parameter int         GAP_COLS      = 1,
  parameter int         COL_TICKS     = 1000,
  parameter logic [7:0] TERM          = 8'h0D
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  input  logic                               sync,
  output logic [CHAR_BITS-1:0]               font_char,
  output logic [$clog2(COLS_PER_CHAR)-1:0]   font_col,
  input  logic [NUM_LEDS-1:0]                font_data,
  output logic [NUM_LEDS-1:0]                ledsOut,
  output logic [$clog2(MAX_CHARS+1)-1:0]     msg_len,
  output logic                               new_msg,
  output logic                               overflow,
  output logic                               rx_drop
);

  localparam int LEN_W      = $clog2(MAX_CHARS + 1);
  localparam int IDX_W      = $clog2(MAX_CHARS);
  localparam int FCOL_W     = $clog2(COLS_PER_CHAR);
  localparam int COLS_TOTAL = COLS_PER_CHAR + GAP_COLS;
  localparam int CCOL_W     = $clog2(COLS_TOTAL);
  localparam int TICK_W     = $clog2(COL_TICKS);

  localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_CHARS);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(COL_TICKS - 1);
  localparam logic [CCOL_W-1:0] LAST_COL   = CCOL_W'(COLS_TOTAL - 1);
  localparam logic [CCOL_W:0]   GLYPH_COLS = (CCOL_W+1)'(COLS_PER_CHAR);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // Two character buffers; front_sel picks the one being displayed.
  logic [CHAR_BITS-1:0] mem [2][MAX_CHARS];

  logic                 sync_p0, sync_p1, sync_edge_p2;
  logic [LEN_W-1:0]     wr_idx, back_len, start_len;
  logic                 commit_pend, front_sel, do_commit;
  logic [0:0]           state;
  logic [IDX_W-1:0]     char_idx;
  logic [CCOL_W-1:0]    col;
  logic [TICK_W-1:0]    tick;
  logic                 is_term, rx_store, col_is_glyph, last_char;

  assign is_term      = (rx_data == TERM);
  assign rx_store     = rx_valid && !commit_pend && !is_term && (wr_idx < MAX_LEN);
  assign do_commit    = commit_pend && (state == IDLE);
  // A sweep starting in the same cycle as a commit shows the newly committed message.
  assign start_len    = do_commit ? back_len : msg_len;
  assign col_is_glyph = ({1'b0, col} < GLYPH_COLS);
  assign last_char    = (LEN_W'(char_idx) == (msg_len - LEN_W'(1)));

  // Sync input register and registered rising-edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      sync_edge_p2 <= 1'b0;
    end else begin
      sync_p0      <= sync;
      sync_p1      <= sync_p0;
      sync_edge_p2 <= sync_p0 & ~sync_p1;
    end
  end

  // Receive framing: write index, overflow, pending commit and drop strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx      <= '0;
      back_len    <= '0;
      overflow    <= 1'b0;
      commit_pend <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      rx_drop <= 1'b0;
      if (rx_valid) begin
        if (commit_pend) begin
          rx_drop <= 1'b1;
        end else if (is_term) begin
          if ((wr_idx != '0) && !overflow) begin
            commit_pend <= 1'b1;
            back_len    <= wr_idx;
          end
          wr_idx   <= '0;
          overflow <= 1'b0;
        end else if (wr_idx < MAX_LEN) begin
          wr_idx <= wr_idx + LEN_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (do_commit) begin
        commit_pend <= 1'b0;
      end
    end
  end

  // Back-buffer character store
  always_ff @(posedge clk) begin
    if (rx_store) begin
      mem[~front_sel][wr_idx[IDX_W-1:0]] <= rx_data[CHAR_BITS-1:0];
    end
  end

  // Buffer swap: flips front/back and publishes the new length while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel <= 1'b0;
      msg_len   <= '0;
      new_msg   <= 1'b0;
    end else begin
      new_msg <= 1'b0;
      if (do_commit) begin
        front_sel <= ~front_sel;
        msg_len   <= back_len;
        new_msg   <= 1'b1;
      end
    end
  end

  // Display sweep: tick/column/char counters, font fetch and LED column register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      char_idx  <= '0;
      col       <= '0;
      tick      <= '0;
      font_char <= '0;
      font_col  <= '0;
      ledsOut   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ledsOut <= '0;
          if (sync_edge_p2 && (start_len != '0)) begin
            state    <= SCAN;
            char_idx <= '0;
            col      <= '0;
            tick     <= '0;
          end
        end
        SCAN: begin
          if (sync_edge_p2) begin
            char_idx <= '0;
            col      <= '0;
            tick     <= '0;
          end else begin
            // Address out at tick 0 edge, ROM data back for the tick 2 edge.
            if ((tick == '0) && col_is_glyph) begin
              font_char <= mem[front_sel][char_idx];
              font_col  <= FCOL_W'(col);
            end
            if (tick == TICK_W'(2)) begin
              ledsOut <= col_is_glyph ? font_data : '0;
            end
            if (tick == LAST_TICK) begin
              tick <= '0;
              if (col == LAST_COL) begin
                col <= '0;
                if (last_char) begin
                  state   <= IDLE;
                  ledsOut <= '0;
                end else begin
                  char_idx <= char_idx + IDX_W'(1);
                end
              end else begin
                col <= col + CCOL_W'(1);
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pov_message_engine.sv
// Testbench for pov_message_engine: table-driven receive/commit vectors followed by
// hand-written sweep, tear-free commit, resync, reset and empty-message sequences.
module tb_pov_message_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        sync;
  logic [6:0]  font_char;
  logic [2:0]  font_col;
  logic [15:0] font_data = '0;
  logic [15:0] ledsOut;
  logic [3:0]  msg_len;
  logic        new_msg;
  logic        overflow;
  logic        rx_drop;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] TERM_B = 8'h0D;

  pov_message_engine #(
    .MAX_CHARS(11), .CHAR_BITS(7), .NUM_LEDS(16), .COLS_PER_CHAR(5),
    .GAP_COLS(1), .COL_TICKS(8), .TERM(TERM_B)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .sync(sync),
    .font_char(font_char), .font_col(font_col), .font_data(font_data),
    .ledsOut(ledsOut), .msg_len(msg_len), .new_msg(new_msg),
    .overflow(overflow), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  // Synchronous font ROM: one-hot column in bits 4:0, character code in bits 15:9.
  always @(posedge clk) font_data <= (16'h1 << font_col) | ({9'b0, font_char} << 9);

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       nm;
    logic [3:0] len;
    logic       ov;
    logic       dr;
  } vec_t;

  vec_t vecs[40];
  int   nvec = 0;

  logic [6:0] exp_msg [0:10];
  int         exp_len;

  task automatic add_vec(input logic v, input logic [7:0] d, input logic nm,
                         input logic [3:0] len, input logic ov, input logic dr);
    vecs[nvec].vld  = v;
    vecs[nvec].data = d;
    vecs[nvec].nm   = nm;
    vecs[nvec].len  = len;
    vecs[nvec].ov   = ov;
    vecs[nvec].dr   = dr;
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ledsOut"},   32'(ledsOut),   0);
    chk({tag, " font_char"}, 32'(font_char), 0);
    chk({tag, " font_col"},  32'(font_col),  0);
    chk({tag, " msg_len"},   32'(msg_len),   0);
    chk({tag, " new_msg"},   32'(new_msg),   0);
    chk({tag, " overflow"},  32'(overflow),  0);
    chk({tag, " rx_drop"},   32'(rx_drop),   0);
  endtask

  // Expected LED column n negedges after sync was raised (sweep started from idle):
  // first column appears after 6 edges, then 8 cycles per column, 6 columns per char.
  function automatic logic [15:0] exp_leds(input int n);
    int c, k, cl;
    if (n < 6) return '0;
    c = (n - 6) / 8;
    if (c >= exp_len * 6) return '0;
    k  = c / 6;
    cl = c % 6;
    if (cl >= 5) return '0;
    return (16'h1 << cl) | ({9'b0, exp_msg[k]} << 9);
  endfunction

  initial begin
    reset = 1'b1;
    sync  = 1'b0;
    drive(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // "HI",TERM with display idle: commit one edge after TERM.
    add_vec(1, "H",    0, 0, 0, 0);
    add_vec(1, "I",    0, 0, 0, 0);
    add_vec(1, TERM_B, 0, 0, 0, 0);
    add_vec(0, 8'h00,  1, 2, 0, 0);
    add_vec(0, 8'h00,  0, 2, 0, 0);
    // 12 chars: overflow after the 12th; TERM clears it, no commit.
    for (int i = 0; i < 11; i++) add_vec(1, 8'h41 + 8'(i), 0, 2, 0, 0);
    add_vec(1, "L",    0, 2, 1, 0);
    add_vec(1, TERM_B, 0, 2, 0, 0);
    add_vec(0, 8'h00,  0, 2, 0, 0);
    // Empty message is discarded.
    add_vec(1, TERM_B, 0, 2, 0, 0);
    add_vec(0, 8'h00,  0, 2, 0, 0);
    // Byte arriving while the commit is pending is dropped; commit still happens.
    add_vec(1, "A",    0, 2, 0, 0);
    add_vec(1, "B",    0, 2, 0, 0);
    add_vec(1, "C",    0, 2, 0, 0);
    add_vec(1, TERM_B, 0, 2, 0, 0);
    add_vec(1, "Z",    1, 3, 0, 1);
    add_vec(0, 8'h00,  0, 3, 0, 0);
    // Restore "HI" for the sweep.
    add_vec(1, "H",    0, 3, 0, 0);
    add_vec(1, "I",    0, 3, 0, 0);
    add_vec(1, TERM_B, 0, 3, 0, 0);
    add_vec(0, 8'h00,  1, 2, 0, 0);
    add_vec(0, 8'h00,  0, 2, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].vld, vecs[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d new_msg", i),  32'(new_msg),  32'(vecs[i].nm));
      chk($sformatf("vec%0d msg_len", i),  32'(msg_len),  32'(vecs[i].len));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ov));
      chk($sformatf("vec%0d rx_drop", i),  32'(rx_drop),  32'(vecs[i].dr));
    end
    drive(1'b0, 8'h00);

    // Full sweep of "HI": 12 columns, gaps at columns 5 and 11, dark afterwards.
    exp_msg[0] = 7'h48;
    exp_msg[1] = 7'h49;
    exp_len    = 2;
    sync = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk);
      chk($sformatf("sweep1 leds n=%0d", n), 32'(ledsOut), 32'(exp_leds(n)));
      if (n == 3) sync = 1'b0;
    end

    // "OK!",TERM during a sweep: commit withheld until idle, display stays "HI",
    // a byte sent meanwhile is dropped.
    sync = 1'b1;
    for (int n = 1; n <= 112; n++) begin
      @(negedge clk);
      chk($sformatf("sweep2 leds n=%0d", n), 32'(ledsOut), 32'(exp_leds(n)));
      chk($sformatf("sweep2 new_msg n=%0d", n), 32'(new_msg), 32'(n == 100));
      chk($sformatf("sweep2 msg_len n=%0d", n), 32'(msg_len), (n >= 100) ? 32'd3 : 32'd2);
      chk($sformatf("sweep2 rx_drop n=%0d", n), 32'(rx_drop), 32'(n == 31));
      drive(1'b0, 8'h00);
      if (n == 3)  sync = 1'b0;
      if (n == 20) drive(1'b1, "O");
      if (n == 21) drive(1'b1, "K");
      if (n == 22) drive(1'b1, "!");
      if (n == 23) drive(1'b1, TERM_B);
      if (n == 30) drive(1'b1, "Q");
    end
    drive(1'b0, 8'h00);

    // Sweep of "OK!" with a resync at column 7; a pending commit waits for the
    // end of the restarted sweep.
    exp_msg[0] = 7'h4F;
    exp_msg[1] = 7'h4B;
    exp_msg[2] = 7'h21;
    exp_len    = 3;
    sync = 1'b1;
    for (int n = 1; n <= 222; n++) begin
      @(negedge clk);
      chk($sformatf("resync leds n=%0d", n), 32'(ledsOut),
          (n >= 70) ? 32'(exp_leds(n - 64)) : 32'(exp_leds(n)));
      chk($sformatf("resync new_msg n=%0d", n), 32'(new_msg), 32'(n == 212));
      chk($sformatf("resync msg_len n=%0d", n), 32'(msg_len), (n >= 212) ? 32'd1 : 32'd3);
      drive(1'b0, 8'h00);
      if (n == 3)  sync = 1'b0;
      if (n == 64) sync = 1'b1;
      if (n == 67) sync = 1'b0;
      if (n == 40) drive(1'b1, "Z");
      if (n == 41) drive(1'b1, TERM_B);
    end
    drive(1'b0, 8'h00);

    // Reset mid-sweep with "ABC" buffered: everything returns to zero.
    exp_msg[0] = 7'h5A;
    exp_len    = 1;
    drive(1'b1, "A");
    @(negedge clk);
    drive(1'b1, "B");
    @(negedge clk);
    drive(1'b1, "C");
    @(negedge clk);
    drive(1'b0, 8'h00);
    sync = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk($sformatf("pre-reset leds n=%0d", n), 32'(ledsOut), 32'(exp_leds(n)));
      if (n == 3) sync = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midsweep reset");
    reset = 1'b0;

    // Sync edge with an empty front message: no sweep.
    sync = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      chk($sformatf("empty sync leds n=%0d", n), 32'(ledsOut), 0);
      chk($sformatf("empty sync font_char n=%0d", n), 32'(font_char), 0);
      if (n == 3) sync = 1'b0;
    end

    // "A",TERM after reset: partial message lost, commits with length 1.
    drive(1'b1, "A");
    @(negedge clk);
    drive(1'b1, TERM_B);
    @(negedge clk);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("post-reset new_msg", 32'(new_msg), 1);
    chk("post-reset msg_len", 32'(msg_len), 1);
    @(negedge clk);
    exp_msg[0] = 7'h41;
    exp_len    = 1;
    sync = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      chk($sformatf("sweepA leds n=%0d", n), 32'(ledsOut), 32'(exp_leds(n)));
      if (n == 3) sync = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
